// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider / tick generator with glitch-free divisor updates.
// Define CLK_DIV_SYNC_EN to add the sync input that phase-aligns all running channels.
module multi_clk_div #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEF_PERIOD = 2,
  parameter int unsigned DEF_HIGH   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CLK_DIV_SYNC_EN
  input  logic                    sync,
`endif
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] period_i,
  input  logic [NUM_CH*WIDTH-1:0] high_i,
  output logic [NUM_CH-1:0]       clk_o,
  output logic [NUM_CH-1:0]       tick_o
);

  typedef enum logic {StIdle, StRun} state_e;

  logic sync_w;
`ifdef CLK_DIV_SYNC_EN
  assign sync_w = sync;
`else
  assign sync_w = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, p_q, h_q, pn_q, hn_q;
    logic             pf_q, clk_q, tick_q;
    state_e           state_q;

    logic [WIDTH-1:0] ld_p, ld_h, eff_p, eff_h, cnt_inc;
    logic             wrap;

    // eff_* is what P/H become if an apply happens on this edge; a same-cycle load wins.
    always_comb begin
      ld_p    = period_i[g*WIDTH +: WIDTH];
      ld_h    = high_i[g*WIDTH +: WIDTH];
      eff_p   = load[g] ? ld_p : (pf_q ? pn_q : p_q);
      eff_h   = load[g] ? ld_h : (pf_q ? hn_q : h_q);
      cnt_inc = cnt_q + WIDTH'(1);
      wrap    = (cnt_q == (p_q - WIDTH'(1)));
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        p_q     <= WIDTH'(DEF_PERIOD);
        h_q     <= WIDTH'(DEF_HIGH);
        pn_q    <= '0;
        hn_q    <= '0;
        pf_q    <= 1'b0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
      end else begin
        if (load[g]) begin
          pn_q <= ld_p;
          hn_q <= ld_h;
          pf_q <= 1'b1;
        end
        unique case (state_q)
          StIdle: begin
            p_q   <= eff_p;
            h_q   <= eff_h;
            pf_q  <= 1'b0;
            cnt_q <= '0;
            if (en[g] && (eff_p != '0)) begin
              state_q <= StRun;
              clk_q   <= (eff_h != '0);
              tick_q  <= 1'b1;
            end else begin
              clk_q  <= 1'b0;
              tick_q <= 1'b0;
            end
          end
          StRun: begin
            if (!en[g]) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              clk_q   <= 1'b0;
              tick_q  <= 1'b0;
            end else if (sync_w || wrap) begin
              // Period start: pending values take effect here and nowhere mid-period.
              p_q   <= eff_p;
              h_q   <= eff_h;
              pf_q  <= 1'b0;
              cnt_q <= '0;
              if (eff_p == '0) begin
                state_q <= StIdle;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
              end else begin
                clk_q  <= (eff_h != '0);
                tick_q <= 1'b1;
              end
            end else begin
              cnt_q  <= cnt_inc;
              clk_q  <= (cnt_inc < h_q);
              tick_q <= 1'b0;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end

    assign clk_o[g]  = clk_q;
    assign tick_o[g] = tick_q;
  end

endmodule

// File: tb/tb_multi_clk_div.sv
// Directed self-checking bench for multi_clk_div (NUM_CH=4, WIDTH=8, defaults P=2/H=1).
module tb_multi_clk_div;

  logic        clk = 1'b0;
  logic        rst;
`ifdef CLK_DIV_SYNC_EN
  logic        sync;
`endif
  logic [3:0]  en, load, clk_o, tick_o;
  logic [31:0] period_i, high_i;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  multi_clk_div #(
    .NUM_CH    (4),
    .WIDTH     (8),
    .DEF_PERIOD(2),
    .DEF_HIGH  (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef CLK_DIV_SYNC_EN
    .sync    (sync),
`endif
    .en      (en),
    .load    (load),
    .period_i(period_i),
    .high_i  (high_i),
    .clk_o   (clk_o),
    .tick_o  (tick_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int p, input int h);
    logic [7:0] pv, hv;
    pv = p[7:0];
    hv = h[7:0];
    period_i[ch*8 +: 8] = pv;
    high_i[ch*8 +: 8]   = hv;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = '0;
    load = '0;
    step();
    rst  = 1'b0;
    chk("rst_clk", {28'd0, clk_o}, 32'd0);
    chk("rst_tick", {28'd0, tick_o}, 32'd0);
  endtask

  initial begin
    logic [3:0] ec, et;
    logic       c1, t1;
    rst      = 1'b1;
    en       = '0;
    load     = '0;
    period_i = '0;
    high_i   = '0;
`ifdef CLK_DIV_SYNC_EN
    sync     = 1'b0;
`endif
    step();
    step();
    chk("reset_clk", {28'd0, clk_o}, 32'd0);
    chk("reset_tick", {28'd0, tick_o}, 32'd0);

    // Defaults P=2 H=1 on channel 0.
    rst = 1'b0;
    en  = 4'b0001;
    for (int j = 0; j < 5; j++) begin
      step();
      ec = {3'b000, (j % 2 == 0)};
      chk("def_clk", {28'd0, clk_o}, {28'd0, ec});
      chk("def_tick", {28'd0, tick_o}, {28'd0, ec});
    end

    // Load P=5 H=2 at cnt=0 of a P=2 period; current period completes first.
    set_ch(0, 5, 2);
    load = 4'b0001;
    step();
    load = '0;
    chk("ld_finish_clk", {28'd0, clk_o}, 32'd0);
    chk("ld_finish_tick", {28'd0, tick_o}, 32'd0);
    for (int j = 0; j < 10; j++) begin
      step();
      chk("p5_clk", {28'd0, clk_o}, {31'd0, (j % 5 < 2)});
      chk("p5_tick", {28'd0, tick_o}, {31'd0, (j % 5 == 0)});
    end

    // Load on the wrap edge applies at that very period start; H=P keeps clk_o high.
    set_ch(0, 3, 3);
    load = 4'b0001;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) load = '0;
      chk("p3h3_clk", {28'd0, clk_o}, 32'd1);
      chk("p3h3_tick", {28'd0, tick_o}, {31'd0, (k % 3 == 0)});
    end

    // Degenerate settings loaded while idle, together with enable.
    do_reset();
    set_ch(0, 3, 0);
    set_ch(1, 4, 7);
    set_ch(2, 1, 1);
    set_ch(3, 1, 0);
    load = 4'hF;
    en   = 4'hF;
    for (int j = 0; j < 13; j++) begin
      step();
      if (j == 0) load = '0;
      et = {1'b1, 1'b1, (j % 4 == 0), (j % 3 == 0)};
      chk("degen_clk", {28'd0, clk_o}, 32'h6);
      chk("degen_tick", {28'd0, tick_o}, {28'd0, et});
    end
    // Channel 1 at cnt=0: P=0 is held pending until the period ends, then idles.
    set_ch(1, 0, 0);
    load = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) load = '0;
      chk("p0_ch1", {30'd0, clk_o[1], tick_o[1]}, {30'd0, (k < 3), 1'b0});
    end

    // Drop en[1] at cnt=3 of P=6, then re-enable; others at defaults.
    do_reset();
    set_ch(1, 6, 3);
    load = 4'b0010;
    en   = 4'hF;
    for (int j = 0; j < 8; j++) begin
      step();
      if (j == 0) load = '0;
      if (j < 4) begin
        c1 = (j % 6 < 3);
        t1 = (j == 0);
      end else if (j < 6) begin
        c1 = 1'b0;
        t1 = 1'b0;
      end else begin
        c1 = (j - 6 < 3);
        t1 = (j == 6);
      end
      ec = {(j % 2 == 0), (j % 2 == 0), c1, (j % 2 == 0)};
      et = {(j % 2 == 0), (j % 2 == 0), t1, (j % 2 == 0)};
      chk("en_drop_clk", {28'd0, clk_o}, {28'd0, ec});
      chk("en_drop_tick", {28'd0, tick_o}, {28'd0, et});
      if (j == 3) en[1] = 1'b0;
      if (j == 5) en[1] = 1'b1;
    end

    // Reset mid-run with P=10 restores the default period.
    do_reset();
    set_ch(0, 10, 5);
    load = 4'b0001;
    en   = 4'b0001;
    for (int j = 0; j < 3; j++) begin
      step();
      if (j == 0) load = '0;
      chk("p10_clk", {28'd0, clk_o}, 32'd1);
      chk("p10_tick", {28'd0, tick_o}, {31'd0, (j == 0)});
    end
    rst = 1'b1;
    step();
    chk("midrst_clk", {28'd0, clk_o}, 32'd0);
    chk("midrst_tick", {28'd0, tick_o}, 32'd0);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("post_rst_clk", {28'd0, clk_o}, {31'd0, (j % 2 == 0)});
      chk("post_rst_tick", {28'd0, tick_o}, {31'd0, (j % 2 == 0)});
    end

`ifdef CLK_DIV_SYNC_EN
    // P=3 and P=4 started out of phase, then aligned by one sync pulse.
    do_reset();
    set_ch(0, 3, 1);
    load = 4'b0001;
    en   = 4'b0001;
    step();
    load = '0;
    step();
    set_ch(1, 4, 1);
    load = 4'b0010;
    en   = 4'b0011;
    step();
    load = '0;
    step();
    sync = 1'b1;
    for (int j = 0; j < 13; j++) begin
      step();
      if (j == 0) sync = 1'b0;
      ec = {2'b00, (j % 4 == 0), (j % 3 == 0)};
      chk("sync_clk", {28'd0, clk_o}, {28'd0, ec});
      chk("sync_tick", {28'd0, tick_o}, {28'd0, ec});
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_clk_div.md
# multi_clk_div

Parametrised, multi-channel programmable clock divider and tick generator for the `clk` domain. It is the successor to the single-channel toggle divider. Each channel produces a registered divided-clock output with a programmable period and high time, plus a one-cycle `tick_o` strobe at every period start. Divisor updates are glitch-free. Peripherals take their slow strobes (baud, scan, blink, debounce) from this block.

## Interface
- `NUM_CH`, default 4: number of independent channels (≥1).
- `WIDTH`, default 32: counter, period and high-time width.
- `DEF_PERIOD`, default 2: active period loaded on reset.
- `DEF_HIGH`, default 1: active high time loaded on reset.
- `clk`, in, 1: sole clock; all logic on its rising edge.
- `rst`, in, 1: synchronous reset, active high.
- `en`, in, NUM_CH: per-channel run enable.
- `load`, in, NUM_CH: per-channel capture strobe for `period_i`/`high_i`.
- `period_i`, in, NUM_CH*WIDTH: channel i uses bits [i*WIDTH +: WIDTH]; period in clk cycles.
- `high_i`, in, NUM_CH*WIDTH: same slicing; cycles `clk_o` is high per period.
- `clk_o`, out, NUM_CH: divided clock, registered.
- `tick_o`, out, NUM_CH: one-cycle strobe at each period start, registered.
- `sync`, in, 1: present only with `CLK_DIV_SYNC_EN`.

## Operation
- Registers per channel:
  - `cnt` (WIDTH bits).
  - Active `P`/`H`.
  - Pending `Pn`/`Hn` and pending flag `pf`.
  - State IDLE/RUN.
  - `clk_o` and `tick_o`.
- Reset:
  - `cnt`=0, state IDLE, `clk_o`=0, `tick_o`=0.
  - `P`=DEF_PERIOD, `H`=DEF_HIGH, `pf`=0.
- `load[i]`: `Pn`/`Hn` ← slice and `pf` ← 1. A later load before the values are applied overwrites them; last load wins.
- Pending apply:
  - `P`/`H` ← `Pn`/`Hn` and `pf` ← 0, at the next period start or at any edge while IDLE.
  - A `load` in the same cycle as a period start applies its new values at that start.
- IDLE (entered when `en[i]`=0 or `P`=0):
  - `cnt`←0, `clk_o`←0, `tick_o`←0.
  - Leave when `en[i]`=1 and the effective `P`≠0. The effective `P` is `Pn` if a load or pending is being applied this edge.
  - On the leaving edge: state←RUN, `cnt`←0, `clk_o`←(0<H), `tick_o`←1.
- RUN, each edge:
  - next = (cnt==P-1) ? 0 : cnt+1.
  - `cnt`←next, `clk_o`←(next<H), `tick_o`←(next==0).
  - Period start is next==0.
- RUN exits:
  - `en[i]`=0 → IDLE on that edge; outputs ←0.
  - `P`=0 after an apply → IDLE.
- Arithmetic:
  - All compares are unsigned, WIDTH bits.
  - P-1 is evaluated only when P≥1.
  - `cnt` never exceeds P-1; no overflow.
- Degenerate settings:
  - H=0 → `clk_o` constant 0.
  - H≥P → `clk_o` constant 1.
  - P=1 → `tick_o` every cycle, `clk_o`=(H≥1).
  - `tick_o` is unaffected by H.
- Priority: `rst` > `en`=0 > `sync` > wrap/increment.
- Channels are fully independent.

## Timing
- Latency from `en` rising at edge k: first `tick_o`/`clk_o` valid after edge k+1.
- Steady state:
  - `tick_o` period = P cycles.
  - `clk_o` high H consecutive cycles, starting on the tick cycle.
- Even P with H=P/2 gives 50% duty. This matches the legacy toggle divider with divisor D at P=2D, H=D.
- New `P`/`H` never truncate or extend the current period; no runt pulses.
- `en` dropping mid-period aborts immediately: outputs are low the next cycle.
- `rst` mid-period: all outputs 0 the next cycle; defaults restored.

## Configuration
- `CLK_DIV_SYNC_EN` defined:
  - Adds the `sync` input.
  - `sync`=1 forces every RUN channel to restart on that edge: pending applied, `cnt`←0, `clk_o`←(0<H), `tick_o`←1.
  - IDLE channels are unaffected.
  - Used to phase-align all channels.
- Not defined: no `sync` port; no restart logic; behaviour otherwise identical.

## Test plan
- Reset then `en`=1, defaults (P=2, H=1): `clk_o` toggles 1,0,1,0…; `tick_o` on every other cycle; first tick one cycle after `en`.
- load P=5, H=2 mid-period of P=2: the current period completes, then a repeating pattern `clk_o` 1,1,0,0,0 with a tick on each first cycle.
- H=0 → `clk_o` stuck 0 with ticks every P; H=7, P=4 → `clk_o` stuck 1; P=1 → tick every cycle; load P=0 → channel idle, outputs 0.
- Drop `en[1]` at cnt=3 of P=6: `clk_o[1]`/`tick_o[1]` 0 next cycle; re-enable → tick after one cycle; channels 0/2/3 undisturbed.
- Assert `rst` mid-run with P=10 loaded: all outputs 0 next cycle; after release and `en`, period reverts to DEF_PERIOD.
- With `CLK_DIV_SYNC_EN`, channels at P=3 and P=4 out of phase, pulse `sync`: both tick on the following cycle, then tick together every 12 cycles.
